// File: rtl/spi_px_shifter.sv
// spi_px_shifter: SPI mode-0 slave that deserialises received pixels and
// serialises processed pixels back out, one PIXEL_BITS word per 8..n sck.
// Ports: clk/nreset_i (async active-low); spi_sck_i/spi_cs_i/spi_sdi_i raw
//   async SPI inputs, spi_sdo_o serial out; px_o/px_rdy_o received pixel and
//   one-cycle strobe; px_i/px_rdy_i pixel to send; underrun_o/overrun_o sticky
//   error flags cleared at the end of each chip-select frame.
module spi_px_shifter #(
   parameter int PIXEL_BITS  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  nreset_i,
   input  logic                  spi_sck_i,
   input  logic                  spi_cs_i,
   input  logic                  spi_sdi_i,
   output logic                  spi_sdo_o,
   output logic [PIXEL_BITS-1:0] px_o,
   output logic                  px_rdy_o,
   input  logic [PIXEL_BITS-1:0] px_i,
   input  logic                  px_rdy_i,
   output logic                  underrun_o,
   output logic                  overrun_o
);

   localparam int CW = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PIXEL_BITS - 1);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   // ---------------- input synchronizers and edge detection ----------------
   logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
   logic sck_prev_q, cs_prev_q;
   logic sck_s, cs_s, sdi_s;
   logic sck_rise, sck_fall, cs_rise, cs_fall;

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         sck_sync_q <= '0;
         cs_sync_q  <= '1;
         sdi_sync_q <= '0;
         sck_prev_q <= 1'b0;
         cs_prev_q  <= 1'b1;
      end else begin
         sck_sync_q[0] <= spi_sck_i;
         cs_sync_q[0]  <= spi_cs_i;
         sdi_sync_q[0] <= spi_sdi_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_sync_q[i] <= sck_sync_q[i-1];
            cs_sync_q[i]  <= cs_sync_q[i-1];
            sdi_sync_q[i] <= sdi_sync_q[i-1];
         end
         sck_prev_q <= sck_s;
         cs_prev_q  <= cs_s;
      end
   end

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign cs_s     = cs_sync_q[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
   assign sck_rise =  sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s &  sck_prev_q;
   assign cs_rise  =  cs_s  & ~cs_prev_q;
   assign cs_fall  = ~cs_s  &  cs_prev_q;

   // ---------------- FSM ----------------
   state_t state_q, state_d;
   logic   start_load, rx_en, tx_fall_en;

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = SHIFT;
         SHIFT:   if (cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A cs rise ends the frame in the same cycle, so sck edges coinciding
   // with it are dropped rather than half-processed.
   always_comb begin
      start_load = 1'b0;
      rx_en      = 1'b0;
      tx_fall_en = 1'b0;
      case (state_q)
         IDLE:  start_load = cs_fall;
         SHIFT: begin
            rx_en      = sck_rise & ~cs_rise;
            tx_fall_en = sck_fall & ~cs_rise;
         end
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  wrap_q, wrap_d;     // last bit captured, next fall starts a word
   logic [PIXEL_BITS-1:0] rx_q, rx_d, rx_word;
   logic [PIXEL_BITS-1:0] px_q, px_d;
   logic                  px_rdy_q, px_rdy_d;
   logic [PIXEL_BITS-1:0] tx_q, tx_d;
   logic [PIXEL_BITS-1:0] txb_q, txb_d;
   logic                  vld_q, vld_d;
   logic                  under_q, under_d;
   logic                  over_q, over_d;
   logic                  last_bit, word_load, tx_shift;

   assign rx_word   = PIXEL_BITS'({rx_q, sdi_s});
   assign last_bit  = rx_en & (cnt_q == CNT_LAST);
   assign word_load = start_load | (tx_fall_en & wrap_q);
   assign tx_shift  = tx_fall_en & ~wrap_q;

   always_comb begin
      cnt_d    = cnt_q;
      wrap_d   = wrap_q;
      rx_d     = rx_q;
      px_d     = px_q;
      px_rdy_d = last_bit;
      tx_d     = tx_q;
      txb_d    = txb_q;
      vld_d    = vld_q;
      under_d  = under_q;
      over_d   = over_q;

      if (start_load)  cnt_d = '0;
      else if (rx_en)  cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

      if (rx_en)    rx_d = rx_word;
      if (last_bit) px_d = rx_word;

      if (last_bit)       wrap_d = 1'b1;
      else if (word_load) wrap_d = 1'b0;

      if (word_load) begin
         // A pixel arriving exactly at word start bypasses the buffer.
         if (px_rdy_i) begin
            tx_d  = px_i;
            vld_d = 1'b0;
         end else if (vld_q) begin
            tx_d  = txb_q;
            vld_d = 1'b0;
         end else begin
            tx_d    = '0;
            under_d = 1'b1;
         end
      end else begin
         if (tx_shift) tx_d = tx_q << 1;
         if (px_rdy_i) begin
            txb_d = px_i;
            vld_d = 1'b1;
            if (vld_q) over_d = 1'b1;
         end
      end

      if (cs_rise) begin
         under_d = 1'b0;
         over_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nreset_i) begin
      if (!nreset_i) begin
         cnt_q    <= '0;
         wrap_q   <= 1'b0;
         rx_q     <= '0;
         px_q     <= '0;
         px_rdy_q <= 1'b0;
         tx_q     <= '0;
         txb_q    <= '0;
         vld_q    <= 1'b0;
         under_q  <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wrap_q   <= wrap_d;
         rx_q     <= rx_d;
         px_q     <= px_d;
         px_rdy_q <= px_rdy_d;
         tx_q     <= tx_d;
         txb_q    <= txb_d;
         vld_q    <= vld_d;
         under_q  <= under_d;
         over_q   <= over_d;
      end
   end

   assign spi_sdo_o  = (state_q == SHIFT) & tx_q[PIXEL_BITS-1];
   assign px_o       = px_q;
   assign px_rdy_o   = px_rdy_q;
   assign underrun_o = under_q;
   assign overrun_o  = over_q;

endmodule

// File: tb/tb_spi_px_shifter.sv
// tb_spi_px_shifter: directed and randomized SPI frames against a word-level
// model of the tx buffer, error flags and received pixel stream.
module tb_spi_px_shifter;

   localparam int PB = 8;
   localparam int H  = 6;   // clk cycles per sck half period

   logic          clk = 1'b0;
   logic          nreset_i, spi_sck_i, spi_cs_i, spi_sdi_i, spi_sdo_o;
   logic [PB-1:0] px_o, px_i;
   logic          px_rdy_o, px_rdy_i, underrun_o, overrun_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_px_shifter #(.PIXEL_BITS(PB), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .nreset_i   (nreset_i),
      .spi_sck_i  (spi_sck_i),
      .spi_cs_i   (spi_cs_i),
      .spi_sdi_i  (spi_sdi_i),
      .spi_sdo_o  (spi_sdo_o),
      .px_o       (px_o),
      .px_rdy_o   (px_rdy_o),
      .px_i       (px_i),
      .px_rdy_i   (px_rdy_i),
      .underrun_o (underrun_o),
      .overrun_o  (overrun_o)
   );

   // Pixel strobe monitor
   int            pulses   = 0;
   int            dbl      = 0;
   int            unstable = 0;
   logic [PB-1:0] mon_px   = '0;
   logic [PB-1:0] prev_px  = '0;
   logic          prev_rdy = 1'b0;

   always @(negedge clk) begin
      if (!nreset_i) begin
         prev_rdy <= 1'b0;
         prev_px  <= px_o;
      end else begin
         if (px_rdy_o) begin
            pulses <= pulses + 1;
            mon_px <= px_o;
            if (prev_rdy) dbl <= dbl + 1;
         end else if (px_o !== prev_px) begin
            unstable <= unstable + 1;
         end
         prev_rdy <= px_rdy_o;
         prev_px  <= px_o;
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // Word-level reference model
   bit            m_valid = 1'b0;
   bit            m_under = 1'b0;
   bit            m_over  = 1'b0;
   logic [PB-1:0] m_buf   = '0;
   logic [PB-1:0] m_cur   = '0;   // word currently being transmitted
   int            exp_pulses = 0;
   logic [PB-1:0] exp_px  = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_load();
      if (m_valid) begin
         m_cur   = m_buf;
         m_valid = 1'b0;
      end else begin
         m_cur   = '0;
         m_under = 1'b1;
      end
   endtask

   task automatic push_px(input logic [PB-1:0] v);
      px_i     = v;
      px_rdy_i = 1'b1;
      wclk(1);
      px_rdy_i = 1'b0;
      if (m_valid) m_over = 1'b1;
      m_buf   = v;
      m_valid = 1'b1;
   endtask

   task automatic frame_start();
      spi_cs_i = 1'b0;
      wclk(8);
      m_load();
      chk("sdo_first_bit", spi_sdo_o, m_cur[PB-1]);
   endtask

   // Frame start where the pixel strobe lands on the same cycle as the
   // entry load (cs fall + 2 sync flops + edge flop).
   task automatic frame_start_same_cycle(input logic [PB-1:0] v);
      spi_cs_i = 1'b0;
      wclk(2);
      px_i     = v;
      px_rdy_i = 1'b1;
      wclk(1);
      px_rdy_i = 1'b0;
      wclk(5);
      m_cur   = v;
      m_valid = 1'b0;
   endtask

   task automatic word(input logic [PB-1:0] rx, input bit inj, input logic [PB-1:0] iv);
      logic [PB-1:0] got;
      logic [PB-1:0] exp_tx;
      exp_tx = m_cur;
      got    = '0;
      for (int i = PB - 1; i >= 0; i--) begin
         spi_sdi_i = rx[i];
         wclk(H);
         got[i] = spi_sdo_o;
         if (i == 4) begin
            chk("mid_underrun", underrun_o, m_under);
            chk("mid_overrun", overrun_o, m_over);
            if (inj) push_px(iv);
         end
         spi_sck_i = 1'b1;
         wclk(H);
         spi_sck_i = 1'b0;
      end
      chk("tx_word", got, exp_tx);
      exp_pulses++;
      exp_px = rx;
      chk("px_rdy_count", pulses, exp_pulses);
      chk("px_o", mon_px, exp_px);
      m_load();   // word-start load on the fall after the last bit
   endtask

   task automatic partial(input logic [PB-1:0] rx, input int nbits);
      for (int i = PB - 1; i >= PB - nbits; i--) begin
         spi_sdi_i = rx[i];
         wclk(H);
         spi_sck_i = 1'b1;
         wclk(H);
         spi_sck_i = 1'b0;
      end
   endtask

   task automatic frame_end();
      wclk(H);
      chk("end_underrun", underrun_o, m_under);
      chk("end_overrun", overrun_o, m_over);
      spi_cs_i = 1'b1;
      wclk(8);
      m_under = 1'b0;
      m_over  = 1'b0;
      chk("idle_underrun", underrun_o, m_under);
      chk("idle_overrun", overrun_o, m_over);
      chk("idle_sdo", spi_sdo_o, 1'b0);
      chk("idle_px_rdy_count", pulses, exp_pulses);
      chk("idle_px_o", px_o, exp_px);
   endtask

   initial begin
      int nw;
      nreset_i  = 1'b0;
      spi_sck_i = 1'b0;
      spi_cs_i  = 1'b1;
      spi_sdi_i = 1'b0;
      px_i      = '0;
      px_rdy_i  = 1'b0;
      wclk(3);

      // Reset state
      chk("rst_px_o", px_o, '0);
      chk("rst_px_rdy", px_rdy_o, 1'b0);
      chk("rst_sdo", spi_sdo_o, 1'b0);
      chk("rst_underrun", underrun_o, 1'b0);
      chk("rst_overrun", overrun_o, 1'b0);
      nreset_i = 1'b1;
      wclk(4);

      // Receive 0xA5 with nothing to send: zeros out, underrun raised
      frame_start();
      word(8'hA5, 1'b0, '0);
      frame_end();

      // Buffered 0x3C goes out as 0,0,1,1,1,1,0,0
      push_px(8'h3C);
      frame_start();
      word(8'($urandom), 1'b0, '0);
      frame_end();

      // Back-to-back words in one frame, 0x56 queued during the first
      frame_start();
      word(8'h12, 1'b1, 8'h56);
      word(8'h34, 1'b0, '0);
      frame_end();

      // cs rises after 5 bits: partial word dropped, then a clean word
      frame_start();
      partial(8'hC3, 5);
      frame_end();
      frame_start();
      word(8'($urandom), 1'b0, '0);
      frame_end();

      // Two strobes before a word: overrun, newest value transmitted
      push_px(8'h11);
      push_px(8'h22);
      wclk(2);
      chk("overrun_idle", overrun_o, m_over);
      frame_start();
      word(8'($urandom), 1'b0, '0);
      frame_end();

      // Strobe coincident with the word-start load
      frame_start_same_cycle(8'h9B);
      word(8'($urandom), 1'b0, '0);
      frame_end();

      // Reset mid-transfer, then a fresh frame
      frame_start();
      partial(8'hF0, 3);
      nreset_i = 1'b0;
      wclk(2);
      chk("midrst_px_o", px_o, '0);
      chk("midrst_px_rdy", px_rdy_o, 1'b0);
      chk("midrst_sdo", spi_sdo_o, 1'b0);
      chk("midrst_underrun", underrun_o, 1'b0);
      chk("midrst_overrun", overrun_o, 1'b0);
      spi_cs_i = 1'b1;
      wclk(2);
      nreset_i = 1'b1;
      wclk(8);
      m_valid = 1'b0;
      m_under = 1'b0;
      m_over  = 1'b0;
      exp_px  = '0;
      push_px(8'h7E);
      frame_start();
      word(8'h7E, 1'b0, '0);
      frame_end();

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         if ($urandom_range(0, 1) == 1) push_px(8'($urandom));
         if ($urandom_range(0, 3) == 0) push_px(8'($urandom));
         frame_start();
         nw = $urandom_range(1, 3);
         for (int w = 0; w < nw; w++)
            word(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
         frame_end();
      end

      chk("px_rdy_single_cycle", dbl, 0);
      chk("px_o_stable", unstable, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_px_shifter.md
SPI_PX_SHIFTER -- requirements
Module: spi_px_shifter

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 8, giving the pixel word width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the flop depth of each input synchronizer.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-004 SHALL have port nreset_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port spi_sck_i, input, 1 bit: raw SPI clock, asynchronous to clk.
REQ-006 SHALL have port spi_cs_i, input, 1 bit: raw SPI chip select, active-low, asynchronous.
REQ-007 SHALL have port spi_sdi_i, input, 1 bit: raw SPI serial data in, asynchronous.
REQ-008 SHALL have port spi_sdo_o, output, 1 bit: SPI serial data out.
REQ-009 SHALL have port px_o, output, PIXEL_BITS: last fully received pixel.
REQ-010 SHALL have port px_rdy_o, output, 1 bit: single-cycle strobe marking px_o as new.
REQ-011 SHALL have port px_i, input, PIXEL_BITS: processed pixel to transmit.
REQ-012 SHALL have port px_rdy_i, input, 1 bit: single-cycle strobe marking px_i as valid.
REQ-013 SHALL have port underrun_o, output, 1 bit: sticky flag, a word was sent with no valid tx data.
REQ-014 SHALL have port overrun_o, output, 1 bit: sticky flag, the tx buffer was overwritten before it was sent.

Function
REQ-015 SHALL pass spi_sck_i, spi_cs_i and spi_sdi_i each through a SYNC_STAGES-deep synchronizer; all edge detection SHALL use the synchronized signals only.
REQ-016 SHALL use SPI mode 0: MSB first; sdi sampled on sync sck rising edges; sdo updated on sync sck falling edges.
REQ-017 SHALL require clk frequency >= 4x sck frequency; behaviour below that ratio is undefined.
REQ-018 SHALL implement FSM IDLE/SHIFT: IDLE->SHIFT on sync cs falling edge; SHIFT->IDLE on sync cs rising edge, from any bit position.
REQ-019 SHALL keep a bit counter of width clog2(PIXEL_BITS), cleared on entry to SHIFT and incremented on each sync sck rising edge in SHIFT.
REQ-020 SHALL wrap the bit counter from PIXEL_BITS-1 to 0, so a single CS frame can carry back-to-back words.
REQ-021 On the sck rising edge that captures bit PIXEL_BITS-1, SHALL update px_o from the rx shift register and assert px_rdy_o on the following clk cycle for exactly 1 cycle.
REQ-022 SHALL hold px_o stable between px_rdy_o pulses.
REQ-023 SHALL discard a partial rx word when cs deasserts mid-word: no px_rdy_o pulse, px_o unchanged.
REQ-024 SHALL keep a tx buffer with a valid flag; px_rdy_i loads px_i into the buffer and sets the flag.
REQ-025 SHALL set overrun_o if px_rdy_i arrives while the flag is already set; the buffer then takes the new value.
REQ-026 SHALL load the tx shift register at word start: on entry to SHIFT, and on the sync sck falling edge after bit PIXEL_BITS-1.
REQ-027 At a word-start load with the flag set, SHALL load the buffer and clear the flag.
REQ-028 At a word-start load with the flag clear, SHALL load all-zeros and set underrun_o.
REQ-029 If px_rdy_i and a word-start load occur in the same cycle, SHALL load px_i directly, leave the flag clear, and set neither overrun_o nor underrun_o.
REQ-030 SHALL drive spi_sdo_o from the tx shift register MSB and shift left on each sync sck falling edge within a word; spi_sdo_o SHALL be 0 in IDLE.
REQ-031 SHALL ignore sck edges in IDLE.
REQ-032 SHALL clear underrun_o and overrun_o on the sync cs rising edge.

Reset
REQ-033 During nreset_i low SHALL force: FSM=IDLE, counter=0, shift registers=0, px_o=0, px_rdy_o=0, spi_sdo_o=0, tx valid flag=0, underrun_o=0, overrun_o=0, synchronizer flops to the idle levels (sck=0, cs=1, sdi=0).
REQ-034 SHALL abandon any in-flight word on reset mid-transfer; after release SHALL wait in IDLE for a fresh sync cs falling edge.

Verification
REQ-035 Reset, cs low, clock in 0xA5 MSB first -> one px_rdy_o pulse, px_o=0xA5, spi_sdo_o=0 throughout, underrun_o=1.
REQ-036 px_rdy_i with px_i=0x3C, then cs low, 8 sck -> sdo bits 0,0,1,1,1,1,0,0; underrun_o=0.
REQ-037 One CS frame with 16 sck carrying 0x12, 0x34; px_rdy_i=0x56 between the words -> two pulses, px_o=0x12 then 0x34; second tx word=0x56.
REQ-038 cs rises after 5 bits -> no px_rdy_o, px_o unchanged, flags cleared; next full word received correctly.
REQ-039 Two px_rdy_i (0x11 then 0x22) before a word -> overrun_o=1; transmitted word=0x22.
REQ-040 nreset_i pulsed low after bit 3 -> all outputs 0; the next full frame sends 0x7E and px_o=0x7E.
